ram_port_arbiter: RTL and testbench

- Shares the single-port synchronous RAM_B between two word-access masters.
- Master 0 is the Multi_CPU data port; master 1 is a debug/loader master (memory dump or program load from the debugger side).
- Each access runs through a request/ready handshake, and the arbiter sequences RAM_B's one-cycle registered read latency.
- Sits between the masters and RAM_B, in the clock domain of RAM_B's clka.

---
 rtl/arch_pkg.sv | 14 +
 rtl/arb_pick2.sv | 29 ++
 rtl/ram_port_arbiter.sv | 112 +++++++++++
 tb/tb_ram_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arch_pkg.sv
// Shared types for the RAM_B port arbiter: FSM state encoding and grant ids.
package arch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: round-robin on ties, or master 0 wins ties
// when FIXED_PRIO is set. A lone requester always wins.
module arb_pick2
    import arch_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

    always_comb begin
        valid = req0 | req1;
        grant = GNT_M0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
                grant = GNT_M0;
            end else begin
                grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
            end
        end else if (req1) begin
            grant = GNT_M1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares single-port RAM_B between the CPU data port (m0) and the debug/loader
// master (m1); each access is IDLE -> ISSUE -> WAIT -> RESP, one per 4 clocks.
module ram_port_arbiter
    import arch_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t state;
    logic       grant_id;
    logic       last_grant;
    logic       acc_we;
    logic       pick_valid;
    logic       pick_grant;

    arb_pick2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .last_grant(last_grant),
        .valid     (pick_valid),
        .grant     (pick_grant)
    );

    // acc_we remembers the access type because ram_we is only high during ISSUE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_id   <= GNT_M0;
            last_grant <= GNT_M1;
            acc_we     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_grant;
                        if (pick_grant == GNT_M1) begin
                            acc_we   <= m1_we;
                            ram_we   <= m1_we;
                            ram_addr <= m1_addr;
                            ram_din  <= m1_wdata;
                        end else begin
                            acc_we   <= m0_we;
                            ram_we   <= m0_we;
                            ram_addr <= m0_addr;
                            ram_din  <= m0_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (grant_id == GNT_M1) begin
                        m1_ready <= 1'b1;
                        if (!acc_we) begin
                            m1_rdata <= ram_dout;
                        end
                    end else begin
                        m0_ready <= 1'b1;
                        if (!acc_we) begin
                            m0_rdata <= ram_dout;
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    m0_ready   <= 1'b0;
                    m1_ready   <= 1'b0;
                    last_grant <= grant_id;
                    state      <= IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by the same
// masters, each with its own registered-read RAM_B model.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;

    logic              rr_m0_ready, rr_m1_ready, rr_ram_we;
    logic [DATA_W-1:0] rr_m0_rdata, rr_m1_rdata, rr_ram_din, rr_ram_dout;
    logic [ADDR_W-1:0] rr_ram_addr;
    logic              fp_m0_ready, fp_m1_ready, fp_ram_we;
    logic [DATA_W-1:0] fp_m0_rdata, fp_m1_rdata, fp_ram_din, fp_ram_dout;
    logic [ADDR_W-1:0] fp_ram_addr;

    logic [DATA_W-1:0] rr_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] fp_mem [0:(1<<ADDR_W)-1];

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
        .ram_addr(rr_ram_addr), .ram_we(rr_ram_we), .ram_din(rr_ram_din),
        .ram_dout(rr_ram_dout)
    );

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .ram_addr(fp_ram_addr), .ram_we(fp_ram_we), .ram_din(fp_ram_din),
        .ram_dout(fp_ram_dout)
    );

    // RAM_B models: read-first, one-cycle registered read.
    always @(posedge clock) begin
        if (rr_ram_we) rr_mem[rr_ram_addr] <= rr_ram_din;
        rr_ram_dout <= rr_mem[rr_ram_addr];
        if (fp_ram_we) fp_mem[fp_ram_addr] <= fp_ram_din;
        fp_ram_dout <= fp_mem[fp_ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int master, input logic req, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (master == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tick();
        tick();
        checkOutput("reset rr_ram_we", 32'(rr_ram_we), 32'd0);
        checkOutput("reset rr_ram_addr", 32'(rr_ram_addr), 32'd0);
        checkOutput("reset rr_m0_ready", 32'(rr_m0_ready), 32'd0);
        checkOutput("reset rr_m1_rdata", rr_m1_rdata, 32'd0);
        checkOutput("reset fp_ram_we", 32'(fp_ram_we), 32'd0);
        reset_n = 1'b1;
        tick();

        // m0 writes 0xDEADBEEF to addr 5
        applyStimulus(0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
        tick();
        checkOutput("wr issue ram_we", 32'(rr_ram_we), 32'd1);
        checkOutput("wr issue ram_addr", 32'(rr_ram_addr), 32'd5);
        checkOutput("wr issue ram_din", rr_ram_din, 32'hDEADBEEF);
        checkOutput("wr issue m0_ready", 32'(rr_m0_ready), 32'd0);
        tick();
        checkOutput("wr wait ram_we", 32'(rr_ram_we), 32'd0);
        checkOutput("wr wait m0_ready", 32'(rr_m0_ready), 32'd0);
        tick();
        checkOutput("wr resp rr_m0_ready", 32'(rr_m0_ready), 32'd1);
        checkOutput("wr resp fp_m0_ready", 32'(fp_m0_ready), 32'd1);
        checkOutput("wr resp ram_we", 32'(rr_ram_we), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();
        checkOutput("wr after m0_ready", 32'(rr_m0_ready), 32'd0);

        // m1 reads addr 5 back
        applyStimulus(1, 1'b1, 1'b0, 10'd5, 32'd0);
        tick();
        checkOutput("rd issue ram_we", 32'(rr_ram_we), 32'd0);
        checkOutput("rd issue ram_addr", 32'(rr_ram_addr), 32'd5);
        tick();
        tick();
        checkOutput("rd resp m1_ready", 32'(rr_m1_ready), 32'd1);
        checkOutput("rd resp m1_rdata", rr_m1_rdata, 32'hDEADBEEF);
        checkOutput("rd resp m0_rdata", rr_m0_rdata, 32'd0);
        checkOutput("rd resp m0_ready", 32'(rr_m0_ready), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();
        checkOutput("rd after m1_ready", 32'(rr_m1_ready), 32'd0);
        checkOutput("rd after m1_rdata hold", rr_m1_rdata, 32'hDEADBEEF);

        // both masters hold req: rr alternates m0,m1; fp always grants m0
        applyStimulus(0, 1'b1, 1'b0, 10'd5, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 10'd5, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checkOutput($sformatf("rr_m0_ready@%0d", k), 32'(rr_m0_ready),
                        (k == 3 || k == 11) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr_m1_ready@%0d", k), 32'(rr_m1_ready),
                        (k == 7 || k == 15) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fp_m0_ready@%0d", k), 32'(fp_m0_ready),
                        (k % 4 == 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fp_m1_ready@%0d", k), 32'(fp_m1_ready), 32'd0);
        end
        applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
        for (int k = 17; k <= 19; k++) begin
            tick();
            checkOutput($sformatf("fp_m1_ready@%0d", k), 32'(fp_m1_ready),
                        (k == 19) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fp_m0_ready@%0d", k), 32'(fp_m0_ready), 32'd0);
        end
        checkOutput("rr_m1_ready@19", 32'(rr_m1_ready), 32'd1);
        checkOutput("rr_m0_rdata contention", rr_m0_rdata, 32'hDEADBEEF);
        applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();

        // reset during WAIT of an m1 read
        applyStimulus(1, 1'b1, 1'b0, 10'd5, 32'd0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("rst mid ram_we", 32'(rr_ram_we), 32'd0);
        checkOutput("rst mid ram_addr", 32'(rr_ram_addr), 32'd0);
        checkOutput("rst mid m1_ready", 32'(rr_m1_ready), 32'd0);
        checkOutput("rst mid m1_rdata", rr_m1_rdata, 32'd0);
        checkOutput("rst mid m0_rdata", rr_m0_rdata, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        applyStimulus(0, 1'b1, 1'b0, 10'd5, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 10'd5, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("post-rst tie m0_ready", 32'(rr_m0_ready), 32'd1);
        checkOutput("post-rst tie m1_ready", 32'(rr_m1_ready), 32'd0);
        checkOutput("post-rst tie m0_rdata", rr_m0_rdata, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();

        // preload addr 3, then m0 reads it and drops req during ISSUE
        applyStimulus(1, 1'b1, 1'b1, 10'd3, 32'h12345678);
        tick();
        tick();
        tick();
        checkOutput("preload m1_ready", 32'(rr_m1_ready), 32'd1);
        applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 10'd3, 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 10'd7, 32'd0);
        tick();
        tick();
        checkOutput("drop m0_ready", 32'(rr_m0_ready), 32'd1);
        checkOutput("drop m0_rdata", rr_m0_rdata, 32'h12345678);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("drop idle m0_ready@%0d", k), 32'(rr_m0_ready), 32'd0);
            checkOutput($sformatf("drop idle ram_we@%0d", k), 32'(rr_ram_we), 32'd0);
            checkOutput($sformatf("drop idle m0_rdata@%0d", k), rr_m0_rdata, 32'h12345678);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
